// File: rtl/glb_weight_fetch_if.sv
// glb_weight_fetch_if
// Bundles the weight-GLB read port and the PE weight stream that
// glb_weight_fetch sits between. The master side is the fetch engine. The
// slave side is the environment: the GLB, which returns r_data one cycle
// after read_req, and the downstream scratchpad, which drives o_ready.

interface glb_weight_fetch_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10
);

  // GLB read port
  logic                     read_req;
  logic [ADDR_BITWIDTH-1:0] r_addr;
  logic [DATA_BITWIDTH-1:0] r_data;

  // Weight stream towards the PE scratchpad
  logic                     o_valid;
  logic                     o_ready;
  logic [DATA_BITWIDTH-1:0] o_data;
  logic                     o_last;

  modport master (
    output read_req,
    output r_addr,
    input  r_data,
    output o_valid,
    input  o_ready,
    output o_data,
    output o_last
  );

  modport slave (
    input  read_req,
    input  r_addr,
    output r_data,
    input  o_valid,
    output o_ready,
    input  o_data,
    input  o_last
  );

endinterface

// File: rtl/glb_weight_fetch.sv
// glb_weight_fetch
// Read-side initiator for the weight global buffer. A start command launches
// a burst of single-word GLB reads. The returned words are captured at the
// GLB's fixed one-cycle latency into a 4-entry skid FIFO and streamed to the
// PE weight scratchpad over valid/ready. The GLB cannot stall, so a read is
// only issued while fifo_count + inflight leaves room for its return word.
//
// Optional feature: define FETCH_STRIDE_EN to add the stride port. The
// address then advances by stride per word instead of by 1.

module glb_weight_fetch #(
  parameter int DATA_BITWIDTH = 16,
  parameter int ADDR_BITWIDTH = 10,
  parameter int CNT_BITWIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_BITWIDTH-1:0] base_addr,
  input  logic [CNT_BITWIDTH-1:0]  word_cnt,
`ifdef FETCH_STRIDE_EN
  input  logic [ADDR_BITWIDTH-1:0] stride,
`endif
  output logic                     busy,
  output logic                     done,
  glb_weight_fetch_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int FIFO_DEPTH = 4;

  state_t                   state;
  logic [ADDR_BITWIDTH-1:0] addr_q;
  logic [ADDR_BITWIDTH-1:0] addr_step;
  logic [CNT_BITWIDTH-1:0]  issue_left;
  logic                     last_popped;

  // Return pipeline: one bit per cycle of GLB latency, plus the tag that
  // marks the burst's final word.
  logic                     inflight;
  logic                     inflight_last;

  // Skid FIFO storage and pointers
  logic [DATA_BITWIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    fifo_tag;
  logic [1:0]               wr_ptr;
  logic [1:0]               rd_ptr;
  logic [2:0]               fifo_count;

  logic                     credit_ok;
  logic                     issue;
  logic                     push;
  logic                     pop;

`ifdef FETCH_STRIDE_EN
  logic [ADDR_BITWIDTH-1:0] stride_q;
  assign addr_step = stride_q;
`else
  assign addr_step = ADDR_BITWIDTH'(1);
`endif

  // The credit test uses only registered terms. The word that is requested
  // in this cycle lands in the FIFO two cycles later. By then every word
  // counted here has been pushed, so the FIFO never has to hold more than 4.
  assign credit_ok = (fifo_count + {2'b00, inflight}) < 3'(FIFO_DEPTH);
  assign issue     = (state == ISSUE) && (issue_left != '0) && credit_ok;
  assign push      = inflight;
  assign pop       = bus.o_valid && bus.o_ready;

  assign bus.read_req = issue;
  assign bus.r_addr   = addr_q;

  // The outputs come straight from registered FIFO state. They are zeroed
  // while the FIFO is empty, so stale entries never show on the bus.
  assign bus.o_valid = (fifo_count != 3'd0);
  assign bus.o_data  = bus.o_valid ? fifo_data[rd_ptr] : '0;
  assign bus.o_last  = bus.o_valid & fifo_tag[rd_ptr];

  assign busy = (state != IDLE);

  // Track the read issued in the previous cycle and whether it was the last one
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (issue_left == CNT_BITWIDTH'(1));
    end
  end

  // Skid FIFO: capture r_data only when a read was issued last cycle; pop on handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[i] <= '0;
      end
      fifo_tag   <= '0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= bus.r_data;
        fifo_tag[wr_ptr]  <= inflight_last;
        wr_ptr            <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Burst controller: latch the command, walk the addresses, signal completion
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      issue_left  <= '0;
      last_popped <= 1'b0;
      done        <= 1'b0;
`ifdef FETCH_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (pop && fifo_tag[rd_ptr]) begin
        last_popped <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (word_cnt == '0) begin
              done <= 1'b1;
            end else begin
              addr_q      <= base_addr;
              issue_left  <= word_cnt;
              last_popped <= 1'b0;
`ifdef FETCH_STRIDE_EN
              stride_q    <= stride;
`endif
              state       <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue) begin
            addr_q     <= addr_q + addr_step;
            issue_left <= issue_left - CNT_BITWIDTH'(1);
            if (issue_left == CNT_BITWIDTH'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!inflight && (fifo_count == 3'd0) && last_popped) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
